// File: rtl/i2c_line_conditioner.sv
// SCL/SDA front end: synchronise, glitch-filter, and derive bus events
// (edges, START/STOP, busy) plus an SCL-held-low watchdog.
module i2c_line_conditioner #(
    parameter int          SYNC_STAGES  = 2,
    parameter int          FILTER_LEN   = 3,
    parameter logic [23:0] STUCK_CYCLES = 24'd1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_f,
    output logic sda_f,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic scl_stuck
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] FILT_LAST = CW'(FILTER_LEN - 1);

    // Index 1 carries SCL, index 0 carries SDA throughout.
    logic [1:0]             pins;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [1:0]             sync_out;
    logic [CW-1:0]          cnt_q [2];
    logic [CW-1:0]          cnt_d [2];
    logic [1:0]             filt_q;
    logic [1:0]             filt_d;

    logic [23:0] stuck_cnt_q;
    logic [23:0] stuck_cnt_d;
    logic        stuck_d;

    logic rise_d;
    logic fall_d;
    logic scl_hold;
    logic start_d;
    logic stop_d;
    logic busy_d;

    assign pins  = {scl_i, sda_i};
    assign scl_f = filt_q[1];
    assign sda_f = filt_q[0];

    always_comb begin
        sync_out = '0;
        filt_d   = filt_q;
        for (int i = 0; i < 2; i++) begin
            sync_out[i] = sync_q[i][SYNC_STAGES-1];
            cnt_d[i]    = '0;
            if (sync_out[i] != filt_q[i]) begin
                if (cnt_q[i] == FILT_LAST) begin
                    filt_d[i] = sync_out[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        stuck_cnt_d = stuck_cnt_q;
        if (filt_d[1]) begin
            stuck_cnt_d = '0;
        end else if (stuck_cnt_q != STUCK_CYCLES) begin
            stuck_cnt_d = stuck_cnt_q + 24'd1;
        end
        stuck_d = (STUCK_CYCLES != 24'd0) && (stuck_cnt_d == STUCK_CYCLES);
    end

    // Strobes are computed from the next filtered levels so they line up
    // with the cycle in which scl_f/sda_f first show the new value.
    always_comb begin
        rise_d   = !filt_q[1] && filt_d[1];
        fall_d   = filt_q[1] && !filt_d[1];
        scl_hold = filt_q[1] && filt_d[1];
        start_d  = scl_hold && filt_q[0] && !filt_d[0];
        stop_d   = scl_hold && !filt_q[0] && filt_d[0];
        busy_d   = bus_busy;
        if (start_d) begin
            busy_d = 1'b1;
        end else if (stop_d || (stuck_d && !scl_stuck)) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= '1;
                cnt_q[i]  <= '0;
            end
            filt_q      <= 2'b11;
            stuck_cnt_q <= '0;
            scl_stuck   <= 1'b0;
            scl_rise    <= 1'b0;
            scl_fall    <= 1'b0;
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
            bus_busy    <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pins[i]};
                cnt_q[i]  <= cnt_d[i];
            end
            filt_q      <= filt_d;
            stuck_cnt_q <= stuck_cnt_d;
            scl_stuck   <= stuck_d;
            scl_rise    <= rise_d;
            scl_fall    <= fall_d;
            start_det   <= start_d;
            stop_det    <= stop_d;
            bus_busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Bench for i2c_line_conditioner: expected bus events are queued as pins
// are driven and matched against events captured from the DUT.
module tb_i2c_line_conditioner;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  stb;
        logic        busy;
        logic        stuck;
        logic [1:0]  lv;
    } ev_t;

    logic clk;
    logic reset;
    logic scl_i;
    logic sda_i;
    logic scl_f;
    logic sda_f;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic bus_busy;
    logic scl_stuck;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    logic m_busy = 1'b0;
    logic mon_en = 1'b0;
    ev_t  exp_q [$];
    ev_t  obs_q [$];

    i2c_line_conditioner #(
        .SYNC_STAGES (2),
        .FILTER_LEN  (3),
        .STUCK_CYCLES(24'd100)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_f    (scl_f),
        .sda_f    (sda_f),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .bus_busy (bus_busy),
        .scl_stuck(scl_stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_busy) busy_cnt <= busy_cnt + 1;
            if ({scl_rise, scl_fall, start_det, stop_det} != 4'b0)
                obs_q.push_back('{cyc, {scl_rise, scl_fall, start_det, stop_det},
                                  bus_busy, scl_stuck, {scl_f, sda_f}});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, need finish");
        $fatal(1, "watchdog");
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean, well-spaced pin change; the expected filtered event lands
    // 5 edges after the first sampling edge.
    task automatic set_pins(input logic s, input logic d);
        logic [3:0] stb;
        stb = 4'b0;
        @(negedge clk);
        if (s != scl_i) stb[3:2] = s ? 2'b10 : 2'b01;
        else if (d != sda_i && s) stb[1:0] = d ? 2'b01 : 2'b10;
        if (stb[1]) m_busy = 1'b1;
        if (stb[0]) m_busy = 1'b0;
        if (stb != 4'b0) exp_q.push_back('{cyc + 5, stb, m_busy, 1'b0, {s, d}});
        scl_i = s;
        sda_i = d;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        scl_i  = 1'b1;
        sda_i  = 1'b1;
        reset  = 1'b1;
        hold(3);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        v = {scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, scl_stuck};
        checks++;
        if (v !== 8'b1100_0000) begin
            errors++;
            $display("FAIL reset_vals: got %b, need 11000000", v);
        end
        hold(10);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL reset_idle: got %0d events, need 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_scl_fall;
        ev_t e;
        ev_t o;
        set_pins(1'b0, 1'b1);
        hold(12);
        set_pins(1'b1, 1'b1);
        hold(12);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL scl_fall ev: got cyc=%0d stb=%b busy=%b stuck=%b lv=%b, need cyc=%0d stb=%b busy=%b stuck=%b lv=%b",
                         o.cyc, o.stb, o.busy, o.stuck, o.lv, e.cyc, e.stb, e.busy, e.stuck, e.lv);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL scl_fall extra: got %0d events, need 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_glitch;
        ev_t e;
        ev_t o;
        @(negedge clk);
        sda_i = 1'b0;
        hold(2);
        sda_i = 1'b1;
        hold(12);
        checks++;
        if (obs_q.size() != 0 || sda_f !== 1'b1) begin
            errors++;
            $display("FAIL glitch2: got %0d events sda_f=%b, need 0 events sda_f=1",
                     obs_q.size(), sda_f);
            obs_q.delete();
        end
        busy_cnt = 0;
        set_pins(1'b1, 1'b0);
        hold(2);
        set_pins(1'b1, 1'b1);
        hold(12);
        checks++;
        if (busy_cnt != 3) begin
            errors++;
            $display("FAIL glitch3 busy: got %0d cycles, need 3", busy_cnt);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL glitch3 ev: got cyc=%0d stb=%b busy=%b lv=%b, need cyc=%0d stb=%b busy=%b lv=%b",
                         o.cyc, o.stb, o.busy, o.lv, e.cyc, e.stb, e.busy, e.lv);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL glitch3 extra: got %0d events, need 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_transaction;
        ev_t  e;
        ev_t  o;
        logic b;
        int   rises;
        int   falls;
        int   starts;
        int   stops;
        int   t_start;
        int   t_stop;
        rises  = 0;
        falls  = 0;
        starts = 0;
        stops  = 0;
        busy_cnt = 0;
        set_pins(1'b1, 1'b0);
        t_start = exp_q[$].cyc;
        hold(20);
        set_pins(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            b = (i == 8) ? 1'b0 : 1'($urandom_range(0, 1));
            hold(10);
            set_pins(1'b0, b);
            hold(10);
            set_pins(1'b1, b);
            hold(20);
            if (i < 8) set_pins(1'b0, b);
        end
        set_pins(1'b1, 1'b1);
        t_stop = exp_q[$].cyc;
        hold(15);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            rises  += o.stb[3];
            falls  += o.stb[2];
            starts += o.stb[1];
            stops  += o.stb[0];
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL txn ev: got cyc=%0d stb=%b busy=%b lv=%b, need cyc=%0d stb=%b busy=%b lv=%b",
                         o.cyc, o.stb, o.busy, o.lv, e.cyc, e.stb, e.busy, e.lv);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL txn extra: got %0d events, need 0", obs_q.size());
            obs_q.delete();
        end
        checks++;
        if (rises != 9 || falls != 9 || starts != 1 || stops != 1) begin
            errors++;
            $display("FAIL txn counts: got r=%0d f=%0d s=%0d p=%0d, need 9 9 1 1",
                     rises, falls, starts, stops);
        end
        checks++;
        if (busy_cnt != t_stop - t_start) begin
            errors++;
            $display("FAIL txn busy: got %0d cycles, need %0d", busy_cnt, t_stop - t_start);
        end
    endtask

    task automatic test_repeated_start;
        ev_t e;
        ev_t o;
        set_pins(1'b1, 1'b0);
        hold(20);
        set_pins(1'b0, 1'b0);
        hold(20);
        set_pins(1'b0, 1'b1);
        hold(10);
        set_pins(1'b1, 1'b1);
        hold(20);
        set_pins(1'b1, 1'b0);
        hold(20);
        set_pins(1'b1, 1'b1);
        hold(20);
        set_pins(1'b0, 1'b1);
        hold(20);
        set_pins(1'b0, 1'b0);
        hold(20);
        set_pins(1'b1, 1'b0);
        hold(20);
        set_pins(1'b1, 1'b1);
        hold(15);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rstart ev: got cyc=%0d stb=%b busy=%b lv=%b, need cyc=%0d stb=%b busy=%b lv=%b",
                         o.cyc, o.stb, o.busy, o.lv, e.cyc, e.stb, e.busy, e.lv);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL rstart extra: got %0d events, need 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_simultaneous;
        ev_t e;
        ev_t o;
        set_pins(1'b0, 1'b0);
        hold(15);
        set_pins(1'b1, 1'b1);
        hold(15);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL simul ev: got cyc=%0d stb=%b busy=%b lv=%b, need cyc=%0d stb=%b busy=%b lv=%b",
                         o.cyc, o.stb, o.busy, o.lv, e.cyc, e.stb, e.busy, e.lv);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL simul extra: got %0d events, need 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_stuck;
        ev_t        e;
        ev_t        o;
        int         t_fall;
        int         t_stuck;
        logic [7:0] v;
        set_pins(1'b1, 1'b0);
        hold(20);
        set_pins(1'b0, 1'b0);
        t_fall = exp_q[$].cyc;
        for (int k = 0; k < 200 && scl_stuck !== 1'b1; k++) @(negedge clk);
        t_stuck = cyc;
        checks++;
        if (scl_stuck !== 1'b1 || t_stuck != t_fall + 99 || bus_busy !== 1'b0) begin
            errors++;
            $display("FAIL stuck_on: got stuck=%b cyc=%0d busy=%b, need 1 %0d 0",
                     scl_stuck, t_stuck, bus_busy, t_fall + 99);
        end
        m_busy = 1'b0;
        hold(10);
        set_pins(1'b1, 1'b0);
        hold(20);
        set_pins(1'b1, 1'b1);
        hold(15);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stuck ev: got cyc=%0d stb=%b busy=%b stuck=%b lv=%b, need cyc=%0d stb=%b busy=%b stuck=%b lv=%b",
                         o.cyc, o.stb, o.busy, o.stuck, o.lv, e.cyc, e.stb, e.busy, e.stuck, e.lv);
            end
        end
        set_pins(1'b0, 1'b1);
        hold(110);
        checks++;
        if (scl_stuck !== 1'b1) begin
            errors++;
            $display("FAIL stuck_hold: got %b, need 1", scl_stuck);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        v = {scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, scl_stuck};
        checks++;
        if (v !== 8'b1100_0000) begin
            errors++;
            $display("FAIL stuck_reset: got %b, need 11000000", v);
        end
        reset = 1'b0;
        exp_q.push_back('{cyc + 5, 4'b0100, 1'b0, 1'b0, 2'b01});
        hold(15);
        set_pins(1'b1, 1'b1);
        hold(15);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() != 0) o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL refilter ev: got cyc=%0d stb=%b busy=%b stuck=%b lv=%b, need cyc=%0d stb=%b busy=%b stuck=%b lv=%b",
                         o.cyc, o.stb, o.busy, o.stuck, o.lv, e.cyc, e.stb, e.busy, e.stuck, e.lv);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL stuck extra: got %0d events, need 0", obs_q.size());
            obs_q.delete();
        end
    endtask

    initial begin
        test_reset;
        test_scl_fall;
        test_glitch;
        test_transaction;
        test_repeated_start;
        test_simultaneous;
        test_stuck;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
